serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//   Upstream feeder for the divisibility-by-5 FSM: accepts a parallel WIDTH-bit word
//   over a valid/ready handshake and emits it serially, MSB first, one bit per clock.
//   out_bit drives the FSM's in_bit; out_first/out_last mark word boundaries.
//   Gapless back-to-back words, so a continuous bitstream is sustained.
// PARAMETERS
//   WIDTH   10   bits per word (min 2); default matches the 10-bit test sequences
// PORTS
//   clk        in   1            single clock, rising edge
//   rst        in   1            synchronous, active-high reset
//   in_data    in   WIDTH        parallel word to serialise
//   in_valid   in   1            in_data valid
//   in_ready   out  1            feeder can accept a word this cycle
//   out_ready  in   1            consumer takes out_bit this cycle (0 = stall/hold)
//   out_bit    out  1            current serial bit (MSB first)
//   out_valid  out  1            out_bit is meaningful
//   out_first  out  1            out_bit is the word's MSB
//   out_last   out  1            out_bit is the word's LSB
//   word_count out  16           words fully emitted (only with SER_WORD_CNT_EN)
// BEHAVIOUR
//   - Clock and reset: one clock (clk); rst is synchronous and active-high.
//   - Reset values: out_bit=0, out_valid=0, out_first=0, out_last=0, in_ready=0 while
//     rst=1; word_count=0. First cycle after rst drops: in_ready=1 (IDLE).
//   - Word register: WIDTH-bit shift register shreg; bit counter bit_cnt, $clog2(WIDTH) bits.
//   - FSM states: IDLE, SHIFT.
//     IDLE : in_ready=1, out_valid=0. Accept (in_valid&in_ready) -> shreg<=in_data,
//            bit_cnt<=WIDTH-1, go SHIFT.
//     SHIFT: out_valid=1, out_bit=shreg[WIDTH-1], out_first=(bit_cnt==WIDTH-1),
//            out_last=(bit_cnt==0). On out_ready: shreg<=shreg<<1, bit_cnt<=bit_cnt-1.
//            On out_ready & bit_cnt==0: word complete; if a new word is accepted the same
//            cycle, reload and stay in SHIFT, else go IDLE.
//   - in_ready = IDLE | (SHIFT & out_last & out_ready): back-to-back, zero bubble.
//   - Latency: word accepted at edge N -> its MSB on out_bit in cycle N+1; a word
//     occupies exactly WIDTH cycles of out_valid absent stalls.
//   - Stall: out_ready=0 in SHIFT holds out_bit, out_first, out_last, shreg, bit_cnt;
//     in_ready=0. out_valid stays 1.
//   - in_valid while in_ready=0: ignored; in_data must be held by source (standard handshake).
//   - Reset mid-word: word in flight discarded, all outputs to reset values next edge.
//   - out_bit forced 0 whenever out_valid=0.
// CONFIGURATION
//   SER_WORD_CNT_EN defined: word_count port present; increments (wraps 16'hFFFF->0)
//     on each cycle with out_valid & out_last & out_ready; cleared by rst.
//   SER_WORD_CNT_EN undefined: word_count port and counter logic absent; all else identical.
// TESTING
//   1 Single word: in_data=10'b0010101010 accepted cycle 0 -> out_bit cycles 1..10 =
//     0,0,1,0,1,0,1,0,1,0; out_first only cycle 1, out_last only cycle 10; IDLE cycle 11.
//   2 Back-to-back: 10'h2AA then 10'h005, in_valid held -> 20 contiguous out_valid cycles,
//     in_ready=1 in cycle 10, second word MSB in cycle 11, out_last in cycle 20.
//   3 Stall: out_ready=0 cycles 4-6 of word 10'b1100110011 -> out_bit holds bit 4 (0)
//     for 4 cycles, remaining bits resume unchanged; out_last lands in cycle 13.
//   4 Reset mid-word: rst=1 at bit 5 -> next edge out_valid=0, in_ready=0; after release
//     in_ready=1, new word 10'h3FF emits ten 1s with fresh out_first.
//   5 Handshake: in_valid=1 during SHIFT (not last bit) -> no accept, in_ready=0, word not
//     lost; accepted exactly at the out_last&out_ready cycle.
//   6 SER_WORD_CNT_EN: send 3 words -> word_count=3 after third out_last; undefined build
//     compiles and passes tests 1-5.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: takes a WIDTH-bit word over valid/ready and emits it MSB first.
// Optional `SER_WORD_CNT_EN adds a 16-bit count of fully emitted words.
module serial_bit_feeder #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last
`ifdef SER_WORD_CNT_EN
    ,
    output logic [15:0]      word_count
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             shifting;
    logic             accept;

    assign shifting  = (state_q == StShift);
    assign out_valid = shifting;
    assign out_bit   = shifting & shreg_q[WIDTH-1];
    assign out_first = shifting && (cnt_q == CntMax);
    assign out_last  = shifting && (cnt_q == '0);

    // Ready on the final bit lets the next word load without a bubble.
    assign in_ready  = !rst && ((state_q == StIdle) || (out_last && out_ready));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = in_data;
                    cnt_d   = CntMax;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (out_ready) begin
                    if (cnt_q == '0) begin
                        if (accept) begin
                            shreg_d = in_data;
                            cnt_d   = CntMax;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        shreg_d = shreg_q << 1;
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SER_WORD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
        end else if (out_valid && out_last && out_ready) begin
            word_count <= word_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: directed scenarios plus random traffic against a bit-queue model.
// Define SER_WORD_CNT_EN to also check word_count.
module tb_serial_bit_feeder;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         out_ready = 1'b0;
    logic         out_bit, out_valid, out_first, out_last;
`ifdef SER_WORD_CNT_EN
    logic [15:0]  word_count;
`endif

    serial_bit_feeder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last)
`ifdef SER_WORD_CNT_EN
        ,
        .word_count(word_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic f;
        logic l;
    } sbit_t;

    sbit_t       exp_q[$];
    int unsigned words_done;
    int          vectors = 0;
    int          miscompares = 0;
    logic        obs_rdy, obs_v, obs_b, obs_f, obs_l;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the queue model, then advance the model.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d, input logic ordy,
                         output logic acc);
        logic  e_rdy;
        sbit_t e;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        obs_rdy = in_ready; obs_v = out_valid; obs_b = out_bit; obs_f = out_first;
        obs_l = out_last;
        e_rdy = !r && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
        e = (exp_q.size() != 0) ? exp_q[0] : '{1'b0, 1'b0, 1'b0};
        check_eq("in_ready", obs_rdy, e_rdy);
        check_eq("out_valid", obs_v, exp_q.size() != 0);
        check_eq("out_bit", obs_b, e.b);
        check_eq("out_first", obs_f, e.f);
        check_eq("out_last", obs_l, e.l);
`ifdef SER_WORD_CNT_EN
        check_eq("word_count", word_count, words_done & 32'hFFFF);
`endif
        acc = v && e_rdy;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            words_done = 0;
        end else begin
            if (ordy && exp_q.size() != 0) begin
                if (exp_q[0].l) words_done++;
                void'(exp_q.pop_front());
            end
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) exp_q.push_back('{d[i], i == W - 1, i == 0});
            end
        end
    endtask

    logic [W-1:0] bits;
    logic         acc;
    int           first_at, last_at, valid_cnt, acc_at;
    logic [W-1:0] pend_d;
    logic         pend_v;

    initial begin
        words_done = 0;
        repeat (2) @(posedge clk);
        // Reset state while rst is held
        cycle(1'b1, 1'b1, 10'h155, 1'b1, acc);
        check_eq("rst_ready", obs_rdy, 1'b0);

        // 1: single word, continuous out_ready
        cycle(1'b0, 1'b1, 10'b0010101010, 1'b1, acc);
        check_eq("t1_acc", acc, 1'b1);
        bits = '0; first_at = -1; last_at = -1;
        for (int k = 1; k <= 11; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, acc);
            if (k <= 10) bits = {bits[W-2:0], obs_b};
            if (obs_f) first_at = k;
            if (obs_l) last_at = k;
            if (k == 11) check_eq("t1_idle", obs_v, 1'b0);
        end
        check_eq("t1_bits", bits, 10'b0010101010);
        check_eq("t1_first", first_at, 1);
        check_eq("t1_last", last_at, 10);

        // 2 + 5: back-to-back, second word offered during SHIFT
        cycle(1'b0, 1'b1, 10'h2AA, 1'b1, acc);
        valid_cnt = 0; acc_at = -1; last_at = -1; first_at = -1;
        for (int k = 1; k <= 21; k++) begin
            cycle(1'b0, acc_at < 0, 10'h005, 1'b1, acc);
            if (acc) acc_at = k;
            if (obs_v) valid_cnt++;
            if (obs_l) last_at = k;
            if (obs_f && k > 1) first_at = k;
        end
        check_eq("t2_acc_at", acc_at, 10);
        check_eq("t2_valid_cnt", valid_cnt, 20);
        check_eq("t2_first2", first_at, 11);
        check_eq("t2_last", last_at, 20);

        // 3: stall cycles 4-6
        cycle(1'b0, 1'b1, 10'b1100110011, 1'b1, acc);
        bits = '0; last_at = -1;
        for (int k = 1; k <= 13; k++) begin
            cycle(1'b0, 1'b0, '0, !(k >= 4 && k <= 6), acc);
            if (k >= 4 && k <= 7) check_eq("t3_hold", obs_b, 1'b0);
            if (!(k >= 4 && k <= 6)) bits = {bits[W-2:0], obs_b};
            if (obs_l) last_at = k;
        end
        check_eq("t3_bits", bits, 10'b1100110011);
        check_eq("t3_last", last_at, 13);

        // 4: reset mid-word then a fresh word
        cycle(1'b0, 1'b1, 10'h1F0, 1'b1, acc);
        for (int k = 1; k <= 4; k++) cycle(1'b0, 1'b0, '0, 1'b1, acc);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        cycle(1'b1, 1'b1, 10'h3FF, 1'b1, acc);
        check_eq("t4_rst_valid", obs_v, 1'b0);
        check_eq("t4_rst_ready", obs_rdy, 1'b0);
        cycle(1'b0, 1'b1, 10'h3FF, 1'b1, acc);
        check_eq("t4_ready", obs_rdy, 1'b1);
        bits = '0; first_at = -1;
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, acc);
            bits = {bits[W-2:0], obs_b};
            if (obs_f) first_at = k;
        end
        check_eq("t4_bits", bits, 10'h3FF);
        check_eq("t4_first", first_at, 1);

`ifdef SER_WORD_CNT_EN
        // 6: three words after a clean reset
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 1'b1, 10'h123, 1'b1, acc);
            for (int k = 0; k < W; k++) cycle(1'b0, 1'b0, '0, 1'b1, acc);
        end
        cycle(1'b0, 1'b0, '0, 1'b1, acc);
        check_eq("t6_count", word_count, 3);
`endif

        // Random traffic; source holds data until accepted
        pend_v = 1'b0; pend_d = '0;
        for (int k = 0; k < 3000; k++) begin
            logic r;
            if (!pend_v && ($urandom_range(0, 2) != 0)) begin
                pend_v = 1'b1;
                pend_d = W'($urandom);
            end
            r = ($urandom_range(0, 199) == 0);
            cycle(r, pend_v, pend_d, $urandom_range(0, 3) != 0, acc);
            if (acc) pend_v = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
